// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external combinational 8-bit ALU through IDLE/EXEC/DONE.
// Build option: define ALU_SEQ_MULTISHIFT_EN for multi-cycle shift/rotate by inb[2:0];
// without it every shift/rotate is a single ALU step and no iteration counter exists.
module alu_sequencer #(
   parameter int unsigned MAX_SHAMT = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ina,
   input  logic [7:0] inb,
   input  logic [3:0] operation,
   output logic       ready,
   output logic [7:0] alu_ina,
   output logic [7:0] alu_inb,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_out,
   input  logic       alu_cr,
   input  logic       alu_ov,
   input  logic       alu_ng,
   input  logic       alu_zr,
   output logic [7:0] result,
   output logic       cr,
   output logic       ov,
   output logic       ng,
   output logic       zr,
   output logic       err,
   output logic       result_valid,
   input  logic       result_ack
);

   localparam logic [3:0] OpAdd       = 4'b0010;
   localparam logic [3:0] OpLs        = 4'b0011;
   localparam logic [3:0] OpSrs       = 4'b0100;
   localparam logic [3:0] OpUrs       = 4'b0101;
   localparam logic [3:0] OpSub       = 4'b0110;
   localparam logic [3:0] OpRro       = 4'b1000;
   localparam logic [3:0] OpLro       = 4'b1001;
   localparam logic [3:0] OpLastValid = 4'b1001;

   // Shift count clamp; counts are 3 bits wide so anything above 7 saturates.
   localparam logic [2:0] ShamtLim = (MAX_SHAMT > 7) ? 3'd7 : 3'(MAX_SHAMT);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [3:0] op_q, op_d;
   logic [7:0] result_q, result_d;
   logic       cr_q, cr_d, ov_q, ov_d, ng_q, ng_d, zr_q, zr_d, err_q, err_d;
   logic       shift_skip;
   logic       exec_last;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OpLs) || (op == OpSrs) || (op == OpUrs) || (op == OpRro) || (op == OpLro);
   endfunction

`ifdef ALU_SEQ_MULTISHIFT_EN
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] req_n;

   assign req_n      = (inb[2:0] > ShamtLim) ? ShamtLim : inb[2:0];
   assign shift_skip = (req_n == 3'd0);
   assign exec_last  = !is_shift(op_q) || (cnt_q == 3'd1);

   // Iteration counter for multi-cycle shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 3'd0;
      else     cnt_q <= cnt_d;
   end
`else
   // A zero clamp turns shifts into pass-through even in single-step mode.
   assign shift_skip = (ShamtLim == 3'd0);
   assign exec_last  = 1'b1;
`endif

   // Next-state, datapath capture and ALU drive.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      cr_d     = cr_q;
      ov_d     = ov_q;
      ng_d     = ng_q;
      zr_d     = zr_q;
      err_d    = err_q;
      alu_ina  = 8'h00;
      alu_inb  = 8'h00;
      alu_op   = 4'h0;
`ifdef ALU_SEQ_MULTISHIFT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d  = ina;
               b_d  = inb;
               op_d = operation;
`ifdef ALU_SEQ_MULTISHIFT_EN
               cnt_d = req_n;
`endif
               if (operation > OpLastValid) begin
                  result_d = 8'h00;
                  err_d    = 1'b1;
                  cr_d     = 1'b0;
                  ov_d     = 1'b0;
                  ng_d     = 1'b0;
                  zr_d     = 1'b1;
                  state_d  = StDone;
               end else if (is_shift(operation) && shift_skip) begin
                  result_d = ina;
                  err_d    = 1'b0;
                  cr_d     = 1'b0;
                  ov_d     = 1'b0;
                  ng_d     = ina[7];
                  zr_d     = (ina == 8'h00);
                  state_d  = StDone;
               end else begin
                  state_d = StExec;
               end
            end
         end
         StExec: begin
            alu_ina = a_q;
            alu_inb = is_shift(op_q) ? 8'h00 : b_q;
            alu_op  = op_q;
            // Feed the partial result back for the next shift step.
            a_d     = alu_out;
`ifdef ALU_SEQ_MULTISHIFT_EN
            cnt_d   = cnt_q - 3'd1;
`endif
            if (exec_last) begin
               result_d = alu_out;
               err_d    = 1'b0;
               ng_d     = alu_ng;
               zr_d     = alu_zr;
               cr_d     = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_cr : 1'b0;
               ov_d     = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_ov : 1'b0;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (result_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         op_q     <= 4'h0;
         result_q <= 8'h00;
         cr_q     <= 1'b0;
         ov_q     <= 1'b0;
         ng_q     <= 1'b0;
         zr_q     <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         cr_q     <= cr_d;
         ov_q     <= ov_d;
         ng_q     <= ng_d;
         zr_q     <= zr_d;
         err_q    <= err_d;
      end
   end

   assign ready        = (state_q == StIdle);
   assign result_valid = (state_q == StDone);
   assign result       = result_q;
   assign cr           = cr_q;
   assign ov           = ov_q;
   assign ng           = ng_q;
   assign zr           = zr_q;
   assign err          = err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MAX_SHAMT, default 7, meaning the largest shift/rotate count honoured (inb[2:0] is clamped to it).
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports start input 1 request strobe; ina input 8 operand A; inb input 8 operand B or shift count; operation input 4 op code.
REQ-005 SHALL have port ready  output  1  high only in IDLE, when start is accepted.
REQ-006 SHALL have ports alu_ina output 8, alu_inb output 8, alu_op output 4; these drive the external 8-bit ALU.
REQ-007 SHALL have ports alu_out input 8, alu_cr input 1, alu_ov input 1, alu_ng input 1, alu_zr input 1; these return the ALU's combinational result and flags.
REQ-008 SHALL have ports result output 8, cr/ov/ng/zr output 1 each, err output 1, result_valid output 1, result_ack input 1.

Function
REQ-009 SHALL use op codes AND=0000, OR=0001, ADD=0010, LS=0011, SRS=0100, URS=0101, SUB=0110, SLT=0111, RRO=1000, LRO=1001; 1010-1111 are invalid.
REQ-010 SHALL implement states IDLE, EXEC, DONE.
REQ-011 SHALL accept a request when start=1 in IDLE, register ina/inb/operation, and enter EXEC on the next edge; start outside IDLE is ignored.
REQ-012 SHALL, for AND/OR/ADD/SUB/SLT, spend exactly one EXEC cycle with alu_ina=A, alu_inb=B, alu_op=operation, capture alu_out and flags at its end, and enter DONE: result_valid asserts 2 cycles after the accepting edge.
REQ-013 SHALL, for LS/SRS/URS/RRO/LRO, set count N=min(inb[2:0],MAX_SHAMT) and spend N EXEC cycles, feeding each captured alu_out back to alu_ina; alu_inb=0 during shifts.
REQ-014 SHALL, when N=0 for a shift op, skip EXEC and enter DONE one cycle after acceptance with result=A, zr=(A==0), ng=A[7], cr=ov=0.
REQ-015 SHALL latch cr and ov from the ALU only for ADD/SUB; cr=ov=0 for all other ops.
REQ-016 SHALL latch zr and ng from the final ALU cycle.
REQ-017 SHALL, for an invalid op, drive no EXEC cycle and enter DONE one cycle after acceptance with result=0, err=1, cr=ov=ng=0, zr=1.
REQ-018 SHALL hold result, flags, err and result_valid stable in DONE until result_ack=1, then return to IDLE on that edge with result_valid=0; result, flags and err retain their values.
REQ-019 SHALL drive alu_ina/alu_inb/alu_op to 0 outside EXEC.
REQ-020 SHALL NOT accept start in the cycle result_ack completes; the earliest new accept is the following IDLE cycle.

Reset
REQ-021 SHALL, on rst=1 at any time including mid-shift, go immediately to IDLE.
REQ-022 SHALL, on reset, force result=0, cr=ov=ng=0, zr=1, err=0, result_valid=0, ready=1, alu_* outputs=0, and clear the iteration count.
REQ-023 SHALL discard any in-flight operation on reset and produce no result_valid for it.

Configuration
REQ-024 SHALL, with ALU_SEQ_MULTISHIFT_EN defined, implement multi-cycle shift/rotate per REQ-013/014.
REQ-025 SHALL, without ALU_SEQ_MULTISHIFT_EN, treat every shift/rotate as N=1 regardless of inb, so all valid ops take one EXEC cycle, and omit the iteration counter.

Verification
REQ-026 SHALL cover: ADD A=0x7F B=0x01 -> result=0x80, ov=1, ng=1, cr=0, zr=0, result_valid 2 cycles after accept.
REQ-027 SHALL cover: SUB A=0x05 B=0x05 -> result=0x00, zr=1, cr=1, ov=0, ng=0.
REQ-028 SHALL cover: LS A=0x81 B=0x03 (MULTISHIFT_EN) -> 3 EXEC cycles, alu_ina sequence 0x81,0x02,0x04, result=0x08; the same stimulus with the macro off -> result=0x02 after 1 EXEC cycle.
REQ-029 SHALL cover: RRO A=0x01 B=0x00 -> result=0x01, no EXEC cycle, result_valid 1 cycle after accept.
REQ-030 SHALL cover: operation=1111 -> err=1, result=0x00, zr=1; and holding result_ack=0 for 5 cycles while pulsing start -> outputs stable and no new accept.
REQ-031 SHALL cover: rst pulsed during the 2nd EXEC cycle of LRO by 5 -> immediate IDLE, reset values per REQ-022, no result_valid.
